key_debounce: RTL

Multi-channel push-button debouncer for the SoC key path. Takes raw, asynchronous, bouncing key pins from the board and produces clean, synchronous, active-high key levels that drive the `PORTIN` inputs of the APB key peripheral. It also produces one-cycle press and release strobes for local use. Each channel is an independent synchroniser plus a 4-state filter FSM with a stability counter.

---
 rtl/key_pkg.sv | 17 +
 rtl/key_debounce_ch.sv | 122 ++++++++++++
 rtl/key_debounce.sv | 51 +++++
 3 files changed

// File: rtl/key_pkg.sv
// ---------------------------------------------------------------------------
// key_pkg
// Shared definitions for the key debouncer: the per-channel filter state
// encoding and the default stability window (20 ms at 50 MHz).
// ---------------------------------------------------------------------------
package key_pkg;

    typedef enum logic [1:0] {
        RELEASED     = 2'b00,
        PRESS_WAIT   = 2'b01,
        PRESSED      = 2'b11,
        RELEASE_WAIT = 2'b10
    } key_state_t;

    localparam int DEBOUNCE_CYCLES_DEFAULT = 1_000_000;

endpackage : key_pkg

// File: rtl/key_debounce_ch.sv
// ---------------------------------------------------------------------------
// key_debounce_ch
// One debounce channel: two-flop synchroniser, four-state filter FSM with a
// stability counter, and registered level / press / release outputs.
//
// Ports
//   clk_i      : clock
//   rst_ni     : asynchronous active-low reset
//   key_i      : normalised raw key (1 = pressed), asynchronous to clk_i
//   key_o      : debounced level, 1 while pressed
//   press_o    : one-cycle strobe when a press is accepted
//   release_o  : one-cycle strobe when a release is accepted
// ---------------------------------------------------------------------------
module key_debounce_ch
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic key_i,
    output logic key_o,
    output logic press_o,
    output logic release_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync2_q;
    key_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             out_q, out_d;
    logic             press_q, press_d;
    logic             release_q, release_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= key_i;
            sync2_q <= sync1_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= RELEASED;
            cnt_q     <= '0;
            out_q     <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            out_q     <= out_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    // Any opposite-level sample in a wait state falls back to the stable
    // state; acceptance always leaves the wait state, so cnt never wraps.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        out_d     = out_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        case (state_q)
            RELEASED: begin
                if (sync2_q) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!sync2_q) begin
                    state_d = RELEASED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                    out_d   = 1'b1;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PRESSED: begin
                if (!sync2_q) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (sync2_q) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d   = RELEASED;
                    cnt_d     = '0;
                    out_d     = 1'b0;
                    release_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = RELEASED;
                cnt_d   = '0;
                out_d   = 1'b0;
            end
        endcase
    end

    assign key_o     = out_q;
    assign press_o   = press_q;
    assign release_o = release_q;

endmodule : key_debounce_ch

// File: rtl/key_debounce.sv
// ---------------------------------------------------------------------------
// key_debounce
// Multi-channel push-button debouncer. Normalises pin polarity so that 1
// always means pressed, then runs an independent debounce channel per key.
// KEY_OUT is registered and glitch-free, suitable for the key peripheral's
// PORTIN directly.
//
// Ports
//   PCLK        : clock
//   PRESETn     : asynchronous active-low reset
//   KEY_RAW     : raw key pins, asynchronous to PCLK
//   KEY_OUT     : debounced levels, 1 = pressed
//   KEY_PRESS   : one-cycle press-accepted strobes
//   KEY_RELEASE : one-cycle release-accepted strobes
// ---------------------------------------------------------------------------
module key_debounce
    import key_pkg::*;
#(
    parameter int NUM_KEYS        = 4,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int ACTIVE_LOW      = 1,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic                PCLK,
    input  logic                PRESETn,
    input  logic [NUM_KEYS-1:0] KEY_RAW,
    output logic [NUM_KEYS-1:0] KEY_OUT,
    output logic [NUM_KEYS-1:0] KEY_PRESS,
    output logic [NUM_KEYS-1:0] KEY_RELEASE
);

    logic [NUM_KEYS-1:0] key_n;

    // Inverting before the synchroniser keeps the filter polarity-agnostic.
    assign key_n = (ACTIVE_LOW != 0) ? ~KEY_RAW : KEY_RAW;

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_ch
        key_debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_ch (
            .clk_i     (PCLK),
            .rst_ni    (PRESETn),
            .key_i     (key_n[g]),
            .key_o     (KEY_OUT[g]),
            .press_o   (KEY_PRESS[g]),
            .release_o (KEY_RELEASE[g])
        );
    end

endmodule : key_debounce
